// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter.
// Owner encoding, request bundle and hold-counter width.
package dmem_arb_pkg;

    localparam int HOLD_W     = 4;
    localparam int ARB_ADDR_W = 32;
    localparam int ARB_DATA_W = 32;

    typedef enum logic {
        OWN_M0 = 1'b0,
        OWN_M1 = 1'b1
    } owner_e;

    typedef struct packed {
        logic                  we;
        logic [ARB_ADDR_W-1:0] addr;
        logic [ARB_DATA_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin winner select with a bounded hold window.
// A zero hold count (no grant last cycle) hands contention to the other port.
module rr_pick2
    import dmem_arb_pkg::*;
#(
    parameter int MAX_HOLD = 4
) (
    input  logic [1:0]        req_i,
    input  owner_e            last_owner_i,
    input  logic [HOLD_W-1:0] hold_cnt_i,
    output logic [1:0]        gnt_o,
    output owner_e            win_o
);

    localparam logic [HOLD_W-1:0] MAX_Q = HOLD_W'(MAX_HOLD);

    logic   keep;
    owner_e other;

    assign keep  = (hold_cnt_i != '0) && (hold_cnt_i < MAX_Q);
    assign other = (last_owner_i == OWN_M0) ? OWN_M1 : OWN_M0;

    // Pick the winner and produce a one-hot grant.
    always_comb begin
        gnt_o = 2'b00;
        win_o = last_owner_i;
        unique case (1'b1)
            (req_i == 2'b01): begin
                win_o = OWN_M0;
                gnt_o = 2'b01;
            end
            (req_i == 2'b10): begin
                win_o = OWN_M1;
                gnt_o = 2'b10;
            end
            (req_i == 2'b11): begin
                win_o = keep ? last_owner_i : other;
                gnt_o = (win_o == OWN_M0) ? 2'b01 : 2'b10;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory.
// Optional perf counters: define DMEM_ARB_PERF_EN.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W   = ARB_ADDR_W,
    parameter int DATA_W   = ARB_DATA_W,
    parameter int MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              MemRead,
    output logic              MemWrite,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [31:0]       perf_grant0,
    output logic [31:0]       perf_grant1,
    output logic [31:0]       perf_stall
`endif
);

    localparam logic [HOLD_W-1:0] MAX_Q = HOLD_W'(MAX_HOLD);

    owner_e              last_owner_q, last_owner_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [1:0]          rd_pend_q, rd_pend_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic [1:0] pick_gnt;
    logic [1:0] gnt;
    owner_e     pick_win;
    logic       any_gnt;
    logic       other_req;
    mem_req_t   m0_r, m1_r, win_r;

    rr_pick2 #(
        .MAX_HOLD (MAX_HOLD)
    ) u_pick (
        .req_i        ({m1_req, m0_req}),
        .last_owner_i (last_owner_q),
        .hold_cnt_i   (hold_cnt_q),
        .gnt_o        (pick_gnt),
        .win_o        (pick_win)
    );

    assign m0_r = '{we: m0_we, addr: m0_addr, wdata: m0_wdata};
    assign m1_r = '{we: m1_we, addr: m1_addr, wdata: m1_wdata};

    // No grant may leave the arbiter while reset is held.
    assign gnt       = rst ? 2'b00 : pick_gnt;
    assign any_gnt   = |gnt;
    assign win_r     = (pick_win == OWN_M0) ? m0_r : m1_r;
    assign other_req = (pick_win == OWN_M0) ? m1_req : m0_req;

    // State register: owner, hold window, read return.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_owner_q <= OWN_M1;
            hold_cnt_q   <= '0;
            rd_pend_q    <= 2'b00;
            rdata_q      <= '0;
        end else begin
            last_owner_q <= last_owner_d;
            hold_cnt_q   <= hold_cnt_d;
            rd_pend_q    <= rd_pend_d;
            rdata_q      <= rdata_d;
        end
    end

    // Next state: hold counting and read capture on a grant.
    always_comb begin
        last_owner_d = last_owner_q;
        hold_cnt_d   = '0;
        rd_pend_d    = 2'b00;
        rdata_d      = rdata_q;
        if (any_gnt) begin
            last_owner_d = pick_win;
            if ((pick_win == last_owner_q) && other_req) begin
                hold_cnt_d = (hold_cnt_q >= MAX_Q) ?
                             MAX_Q : hold_cnt_q + 1'b1;
            end else begin
                hold_cnt_d = HOLD_W'(1);
            end
            if (!win_r.we) begin
                rd_pend_d = gnt;
                rdata_d   = mem_rdata;
            end
        end
    end

    // Outputs: memory drive, grants and gated read return.
    always_comb begin
        m0_gnt    = gnt[0];
        m1_gnt    = gnt[1];
        MemWrite  = any_gnt & win_r.we;
        MemRead   = any_gnt & ~win_r.we;
        mem_addr  = any_gnt ? win_r.addr : '0;
        mem_wdata = any_gnt ? win_r.wdata : '0;
        m0_rvalid = rd_pend_q[0] & ~rst;
        m1_rvalid = rd_pend_q[1] & ~rst;
        m0_rdata  = m0_rvalid ? rdata_q : '0;
        m1_rdata  = m1_rvalid ? rdata_q : '0;
        busy      = m0_req | m1_req;
    end

`ifdef DMEM_ARB_PERF_EN
    logic [31:0] pg0_q, pg1_q, pst_q;
    logic [1:0]  stall;

    assign stall = {m1_req & ~gnt[1], m0_req & ~gnt[0]};

    // Wrapping grant and stall counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            pg0_q <= '0;
            pg1_q <= '0;
            pst_q <= '0;
        end else begin
            pg0_q <= pg0_q + {31'b0, gnt[0]};
            pg1_q <= pg1_q + {31'b0, gnt[1]};
            pst_q <= pst_q + {31'b0, stall[0]}
                           + {31'b0, stall[1]};
        end
    end

    assign perf_grant0 = pg0_q;
    assign perf_grant1 = pg1_q;
    assign perf_stall  = pst_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 256x32 memory.
// Perf counter checks run when DMEM_ARB_PERF_EN is defined.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        MemRead, MemWrite, busy;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef DMEM_ARB_PERF_EN
    logic [31:0] pg0, pg1, pst;
    logic [31:0] s_g, s_st;
`endif

    logic [31:0] mem [0:255];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[9:2]];

    always @(posedge clk)
        if (MemWrite) mem[mem_addr[9:2]] <= mem_wdata;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_HOLD(4)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
        .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
        .m1_rdata(m1_rdata),
        .MemRead(MemRead), .MemWrite(MemWrite),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
`ifdef DMEM_ARB_PERF_EN
        ,
        .perf_grant0(pg0), .perf_grant1(pg1),
        .perf_stall(pst)
`endif
    );

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance to the next negedge; inputs change there.
    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[4] = 32'hDEADBEEF;
        rst = 1'b1;
        m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
        cyc();
        // Requests during reset must not be granted.
        m0_req = 1; m0_addr = 32'h10;
        #1;
        chk("rst_m0_gnt", {31'b0, m0_gnt}, 0);
        chk("rst_memrd", {31'b0, MemRead}, 0);
        chk("rst_m0_rv", {31'b0, m0_rvalid}, 0);
        chk("rst_m1_rd", m1_rdata, 0);
        m0_req = 0;
        cyc();

        // Single m0 read of preloaded word 4.
        rst = 0;
        m0_req = 1; m0_we = 0; m0_addr = 32'h10;
        #1;
        chk("rd_m0_gnt", {31'b0, m0_gnt}, 1);
        chk("rd_m1_gnt", {31'b0, m1_gnt}, 0);
        chk("rd_memrd", {31'b0, MemRead}, 1);
        chk("rd_addr", mem_addr, 32'h10);
        chk("rd_busy", {31'b0, busy}, 1);
        cyc();
        m0_req = 0;
        #1;
        chk("rd_m0_rv", {31'b0, m0_rvalid}, 1);
        chk("rd_m0_data", m0_rdata, 32'hDEADBEEF);
        chk("rd_m1_rv", {31'b0, m1_rvalid}, 0);
        chk("rd_m1_data", m1_rdata, 0);
        chk("idle_memrd", {31'b0, MemRead}, 0);
        chk("idle_addr", mem_addr, 0);
        chk("idle_busy", {31'b0, busy}, 0);
        cyc();

        // m0 write then m1 read of same word.
        m0_req = 1; m0_we = 1; m0_addr = 32'h20;
        m0_wdata = 32'h12345678;
        #1;
        chk("wr_m0_gnt", {31'b0, m0_gnt}, 1);
        chk("wr_memwr", {31'b0, MemWrite}, 1);
        chk("wr_wdata", mem_wdata, 32'h12345678);
        cyc();
        m0_req = 0; m0_we = 0;
        m1_req = 1; m1_we = 0; m1_addr = 32'h20;
        #1;
        chk("raw_m1_gnt", {31'b0, m1_gnt}, 1);
        chk("raw_m0_rv", {31'b0, m0_rvalid}, 0);
        chk("raw_m1_rv0", {31'b0, m1_rvalid}, 0);
        cyc();
        m1_req = 0;
        #1;
        chk("raw_m1_rv", {31'b0, m1_rvalid}, 1);
        chk("raw_m1_data", m1_rdata, 32'h12345678);
        chk("raw_m0_data", m0_rdata, 0);
        cyc();

        // m1 alone for 10 cycles, back-to-back reads.
        for (int i = 0; i < 10; i++) begin
            m1_req = 1; m1_we = 0; m1_addr = 32'h10;
            #1;
            chk($sformatf("solo_gnt%0d", i), {31'b0, m1_gnt}, 1);
            if (i > 0) begin
                chk($sformatf("solo_rv%0d", i),
                    {31'b0, m1_rvalid}, 1);
                chk($sformatf("solo_d%0d", i),
                    m1_rdata, 32'hDEADBEEF);
            end
            cyc();
        end
        m1_req = 0;
        #1;
        chk("solo_last_rv", {31'b0, m1_rvalid}, 1);
        cyc();

        // Continuous contention: runs of four.
        for (int i = 0; i < 12; i++) begin
            m0_req = 1; m0_we = 0; m0_addr = 32'h10;
            m1_req = 1; m1_we = 0; m1_addr = 32'h20;
            #1;
`ifdef DMEM_ARB_PERF_EN
            if (i == 0) begin
                s_g  = pg0 + pg1;
                s_st = pst;
            end
            if (i == 8) begin
                chk("perf_grants", pg0 + pg1 - s_g, 8);
                chk("perf_stall", pst - s_st, 8);
            end
`endif
            chk($sformatf("rr_m0_%0d", i), {31'b0, m0_gnt},
                ((i / 4) % 2 == 0) ? 1 : 0);
            chk($sformatf("rr_m1_%0d", i), {31'b0, m1_gnt},
                ((i / 4) % 2 == 1) ? 1 : 0);
            cyc();
        end
        m0_req = 0; m1_req = 0;
        cyc();

        // Reset right after a read grant drops the response.
        m0_req = 1; m0_addr = 32'h10;
        #1;
        chk("mid_m0_gnt", {31'b0, m0_gnt}, 1);
        cyc();
        m0_req = 0; m1_req = 1; rst = 1;
        #1;
        chk("mid_m0_rv", {31'b0, m0_rvalid}, 0);
        chk("mid_m0_data", m0_rdata, 0);
        chk("mid_m1_gnt", {31'b0, m1_gnt}, 0);
        chk("mid_memrd", {31'b0, MemRead}, 0);
        cyc();
        rst = 0; m1_req = 0;
        #1;
        chk("post_m0_rv", {31'b0, m0_rvalid}, 0);
        chk("post_m1_rv", {31'b0, m1_rvalid}, 0);
        cyc();
        m0_req = 1; m1_req = 1;
        #1;
        chk("post_m0_gnt", {31'b0, m0_gnt}, 1);
        chk("post_m1_gnt", {31'b0, m1_gnt}, 0);
        cyc();
        m0_req = 0; m1_req = 0;
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
